wrr_vc_arbiter: RTL
===================

# wrr_vc_arbiter

Parametrised weighted round-robin virtual-channel arbiter. It replaces the fixed four-channel mux / WRR / VC-table trio with a single block. The block holds a run-time programmable per-channel weight table and grants eligible channels in rotating order, each for up to `weight` consecutive cycles. It also steers the granted channel's data word to the output. It sits between the per-VC FIFOs (whose not-empty and not-paused status forms `req`) and the link transmitter.

## Interface
- `N_VC`, 4: number of virtual channels, 2..16.
- `WEIGHT_W`, 3: weight width in bits; weight range 0..2^WEIGHT_W-1.
- `DATA_W`, 1: data width per channel.
- `DEFAULT_WEIGHT`, 1: reset value of every table entry.
- `VC_W`, derived `$clog2(N_VC)`: channel index width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state at the next edge.
- `req` in N_VC: per-channel eligibility request (FIFO not empty and not paused).
- `data_in` in N_VC*DATA_W: channel data, with channel i at slice [i*DATA_W +: DATA_W].
- `edit_weight` in 1: weight-table write strobe.
- `vc_assign` in VC_W: channel index for the write.
- `weight_assign` in WEIGHT_W: weight value for the write.
- `grant_valid` out 1: registered; a grant is active.
- `grant_id` out VC_W: registered; the granted channel.
- `grant_onehot` out N_VC: registered; one-hot form of `grant_id`, all zeros when not valid.
- `weight` out WEIGHT_W: table entry for `grant_id`.
- `data_out` out DATA_W: combinational; `data_in` slice for `grant_id` when `grant_valid`, else 0.
- `wr_error` out 1: registered one-cycle pulse when a write is rejected.

## Operation
- **Weight table.** N_VC entries, each reset to `DEFAULT_WEIGHT`. On an edge with `edit_weight`=1 and `vc_assign` < N_VC, the entry is written. If `vc_assign` ≥ N_VC (only possible when N_VC is not a power of two), the table is unchanged and `wr_error`=1 for one cycle.
- **Eligibility.** Channel i is eligible when `req[i]`=1 and its weight ≠ 0. Weight 0 disables the channel.
- **Picker.** The first eligible channel at or after start pointer `s`, searching upward modulo N_VC.
- **FSM with two states, IDLE and GRANT.**
  - IDLE: `grant_valid`=0. At an edge where any channel is eligible, pick from `s`=`ptr`, go to GRANT, load `credit` with weight−1. Otherwise stay in IDLE.
  - GRANT, current channel still eligible and `credit`≠0: keep the grant and decrement `credit`.
  - GRANT, current channel ineligible or `credit`=0: re-pick from `s`=`grant_id`+1 modulo N_VC.
    - If the current channel is the only eligible one, it is re-granted with a fresh credit.
    - If nothing is eligible, go to IDLE and set `ptr`=`grant_id`+1.
- **Grant length.** A channel holding `req` receives exactly `weight` consecutive grant cycles per turn.
- **Writes during a grant.**
  - Arbitration at an edge uses the table contents from before that edge's write.
  - A write to the currently granted channel does not alter `credit`. The new value applies at the next reload.
  - Writing 0 to the current channel ends its grant at the following edge.
- **Reset values.** `grant_valid`=0, `grant_id`=0, `grant_onehot`=0, `wr_error`=0, `ptr`=0, `credit`=0, state IDLE, all weights `DEFAULT_WEIGHT`. While `reset` is asserted `data_out`=0.
- **Reset during a grant.** Reset mid-burst drops the grant at that edge. No credit is retained.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge t gives `grant_valid` from t.
- `req` deassertion at edge t gives a new grant or `grant_valid`=0 after edge t. No extra bubble.
- Switching between channels is back-to-back with no idle cycle.
- `data_out` and `weight` follow `grant_id` combinationally with zero latency.
- `wr_error` is asserted in the cycle after the offending write edge.

## Structure
- Package `wrr_vc_pkg` holds:
  - the state enum (IDLE, GRANT);
  - the `clog2`-derived width helper;
  - the default parameter constants.
- Sub-module `wrr_rr_picker` is a combinational rotating-priority picker.
  - Inputs: eligible vector and start index.
  - Outputs: `found` and the picked index.
  - It is instantiated once.
- The table, FSM, credit counter and data mux stay in the top module.

## Test plan
- **Round robin at defaults.** N_VC=4, all weights 1, `req`=4'b1111 after reset → `grant_id` 0,1,2,3,0,… one cycle each, `grant_valid` continuous.
- **Weighted sequence.** Write weights {3,1,2,0} for channels 0..3, `req`=4'b1111 → grant sequence 0,0,0,1,2,2,0,0,0,…; channel 3 is never granted.
- **Request drop mid-burst.** Weights {4,1,1,1}; drop `req[0]` during its second grant cycle → at the next edge `grant_id`=1, no idle cycle.
- **Single requester and idle.** Only `req[2]`=1 with weight 2 → `grant_id`=2 continuously. Then drop `req` → `grant_valid`=0 the next cycle. Then reassert `req[0]` → grant channel 0, because `ptr`=3 and the search wraps.
- **Rejected write.** N_VC=5, `edit_weight` with `vc_assign`=6 → `wr_error`=1 for one cycle, table unchanged.
- **Reset mid-burst.** Reset asserted mid-burst on channel 1 with weight 3 → next cycle `grant_valid`=0, `grant_id`=0, `data_out`=0, all weights back to 1. After release, the first grant goes to channel 0.

Source files
------------

// File: rtl/wrr_vc_pkg.sv
// Shared types and defaults for the weighted round-robin VC arbiter.
package wrr_vc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int DEF_N_VC     = 4;
  localparam int DEF_WEIGHT_W = 3;
  localparam int DEF_DATA_W   = 1;
  localparam int DEF_WEIGHT   = 1;

  // Channel index width; never below one bit so ports stay legal.
  function automatic int vc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wrr_rr_picker.sv
// Combinational rotating-priority picker: first set bit of elig at or after
// start, searching upward modulo N_VC.
module wrr_rr_picker
  import wrr_vc_pkg::*;
#(
  parameter int N_VC = DEF_N_VC,
  parameter int VC_W = vc_width(DEF_N_VC)
) (
  input  logic [N_VC-1:0] elig,
  input  logic [VC_W-1:0] start,
  output logic            found,
  output logic [VC_W-1:0] idx
);

  logic [VC_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_VC - 1; i >= 0; i--) begin
      cand = VC_W'((int'(start) + i) % N_VC);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wrr_vc_arbiter.sv
// Weighted round-robin VC arbiter: programmable weight table, credit-based
// burst FSM, registered grant and combinational data steering.
module wrr_vc_arbiter
  import wrr_vc_pkg::*;
#(
  parameter int N_VC           = DEF_N_VC,
  parameter int WEIGHT_W       = DEF_WEIGHT_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int DEFAULT_WEIGHT = DEF_WEIGHT,
  localparam int VC_W          = vc_width(N_VC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_VC-1:0]          req,
  input  logic [N_VC*DATA_W-1:0]   data_in,
  input  logic                     edit_weight,
  input  logic [VC_W-1:0]          vc_assign,
  input  logic [WEIGHT_W-1:0]      weight_assign,
  output logic                     grant_valid,
  output logic [VC_W-1:0]          grant_id,
  output logic [N_VC-1:0]          grant_onehot,
  output logic [WEIGHT_W-1:0]      weight,
  output logic [DATA_W-1:0]        data_out,
  output logic                     wr_error
);

  logic [WEIGHT_W-1:0] weight_q [N_VC];
  logic [WEIGHT_W-1:0] weight_d [N_VC];
  state_e              state_q, state_d;
  logic [VC_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                grant_valid_q, grant_valid_d;
  logic [VC_W-1:0]     grant_id_q, grant_id_d;
  logic [N_VC-1:0]     grant_onehot_q, grant_onehot_d;
  logic                wr_error_q, wr_error_d;

  logic [N_VC-1:0]     elig;
  logic [VC_W-1:0]     next_id;
  logic [VC_W-1:0]     pick_start;
  logic                pick_found;
  logic [VC_W-1:0]     pick_idx;

  always_comb begin
    for (int i = 0; i < N_VC; i++) begin
      elig[i] = req[i] && (weight_q[i] != '0);
    end
  end

  assign next_id    = (grant_id_q == VC_W'(N_VC - 1)) ? '0 : grant_id_q + VC_W'(1);
  assign pick_start = (state_q == ST_IDLE) ? ptr_q : next_id;

  wrr_rr_picker #(.N_VC(N_VC), .VC_W(VC_W)) u_picker (
    .elig  (elig),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Table writes take effect after this edge; arbitration below reads weight_q.
  always_comb begin
    weight_d   = weight_q;
    wr_error_d = 1'b0;
    if (edit_weight) begin
      if (int'(vc_assign) < N_VC) weight_d[vc_assign] = weight_assign;
      else                        wr_error_d = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d       = ST_GRANT;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_idx;
          credit_d      = weight_q[pick_idx] - WEIGHT_W'(1);
        end
      end
      default: begin
        if (elig[grant_id_q] && (credit_q != '0)) begin
          credit_d = credit_q - WEIGHT_W'(1);
        end else if (pick_found) begin
          grant_id_d = pick_idx;
          credit_d   = weight_q[pick_idx] - WEIGHT_W'(1);
        end else begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          ptr_d         = next_id;
          credit_d      = '0;
        end
      end
    endcase
    grant_onehot_d = grant_valid_d ? (N_VC'(1) << grant_id_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_VC; i++) weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
      state_q        <= ST_IDLE;
      ptr_q          <= '0;
      credit_q       <= '0;
      grant_valid_q  <= 1'b0;
      grant_id_q     <= '0;
      grant_onehot_q <= '0;
      wr_error_q     <= 1'b0;
    end else begin
      weight_q       <= weight_d;
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      credit_q       <= credit_d;
      grant_valid_q  <= grant_valid_d;
      grant_id_q     <= grant_id_d;
      grant_onehot_q <= grant_onehot_d;
      wr_error_q     <= wr_error_d;
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < N_VC; i++) begin
      if (grant_valid_q && !reset && (grant_id_q == VC_W'(i))) begin
        data_out = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  assign weight       = weight_q[grant_id_q];
  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign grant_onehot = grant_onehot_q;
  assign wr_error     = wr_error_q;

endmodule
